// File: rtl/score_popup_if.sv
`default_nettype none
// ============================================================================
// Module   : score_popup_if
// Brief    : Trigger handshake and per-slot popup render bus.
// Revision : 1.0
// ============================================================================
interface score_popup_if #(
    parameter int NUM_SLOTS = 4
);
    logic                    clear;
    logic                    trigger;
    logic [7:0]              trigger_value;
    logic                    trigger_ready;
    logic [NUM_SLOTS-1:0]    slot_active;
    logic [NUM_SLOTS*10-1:0] slot_y;
    logic [NUM_SLOTS*8-1:0]  slot_fade;
    logic [NUM_SLOTS*8-1:0]  slot_value;
    logic [7:0]              dropped_count;

    modport master (
        output clear, trigger, trigger_value,
        input  trigger_ready, slot_active, slot_y, slot_fade, slot_value, dropped_count
    );

    modport slave (
        input  clear, trigger, trigger_value,
        output trigger_ready, slot_active, slot_y, slot_fade, slot_value, dropped_count
    );
endinterface
`default_nettype wire

// File: rtl/score_popup_engine.sv
`default_nettype none
// ============================================================================
// Module   : score_popup_engine
// Brief    : Pool of rising/fading score popups, one animation tick per frame.
// Revision : 1.0
// ============================================================================
module score_popup_engine #(
    parameter int         NUM_SLOTS       = 4,
    parameter int         STEPS           = 8,
    parameter int         FRAMES_PER_STEP = 16,
    parameter logic [7:0] FADE_STEP       = 8'h20,
    parameter logic [9:0] RISE_STEP       = 10'd1
) (
    input  wire logic     frame_clk,
    input  wire logic     reset,
    score_popup_if.slave  bus
);

    localparam int c_DIV_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int c_STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(FRAMES_PER_STEP - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } slot_state_t;

    slot_state_t         r_state [NUM_SLOTS];
    logic [c_DIV_W-1:0]  r_div   [NUM_SLOTS];
    logic [c_STEP_W-1:0] r_step  [NUM_SLOTS];
    logic [9:0]          r_y     [NUM_SLOTS];
    logic [7:0]          r_fade  [NUM_SLOTS];
    logic [7:0]          r_value [NUM_SLOTS];
    logic [7:0]          r_dropped;

    logic [NUM_SLOTS-1:0] w_active;
    logic [NUM_SLOTS-1:0] w_idle;
    logic [NUM_SLOTS-1:0] w_alloc_oh;
    logic                 w_ready;
    logic                 w_accept;

    function automatic logic [7:0] f_fade_add(input logic [7:0] a);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, FADE_STEP};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_active[i] = (r_state[i] == S_RUN);
        end
    end

    // Lowest idle slot: isolate the least significant set bit of the idle mask.
    assign w_idle     = ~w_active;
    assign w_alloc_oh = w_idle & (~w_idle + NUM_SLOTS'(1));
    assign w_ready    = |w_idle;
    assign w_accept   = bus.trigger & w_ready;

    always_ff @(posedge frame_clk) begin
        if (reset || bus.clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
                r_div[i]   <= '0;
                r_step[i]  <= '0;
                r_y[i]     <= '0;
                r_fade[i]  <= '0;
                r_value[i] <= '0;
            end
            if (reset) begin
                r_dropped <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_state[i] == S_RUN) begin
                    if (r_div[i] == c_DIV_LAST) begin
                        r_div[i] <= '0;
                        if (r_step[i] == c_STEP_LAST) begin
                            r_state[i] <= S_IDLE;
                            r_step[i]  <= '0;
                            r_y[i]     <= '0;
                            r_fade[i]  <= '0;
                            r_value[i] <= '0;
                        end else begin
                            r_step[i] <= r_step[i] + c_STEP_W'(1);
                            r_y[i]    <= r_y[i] + RISE_STEP;
                            r_fade[i] <= f_fade_add(r_fade[i]);
                        end
                    end else begin
                        r_div[i] <= r_div[i] + c_DIV_W'(1);
                    end
                end else if (w_accept && w_alloc_oh[i]) begin
                    r_state[i] <= S_RUN;
                    r_div[i]   <= '0;
                    r_step[i]  <= '0;
                    r_y[i]     <= '0;
                    r_fade[i]  <= '0;
                    r_value[i] <= bus.trigger_value;
                end
            end
            if (bus.trigger && !w_ready && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

    always_comb begin
        bus.slot_y     = '0;
        bus.slot_fade  = '0;
        bus.slot_value = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.slot_y[10*i +: 10]   = w_active[i] ? r_y[i]    : 10'd0;
            bus.slot_fade[8*i +: 8]  = w_active[i] ? r_fade[i] : 8'd0;
            bus.slot_value[8*i +: 8] = r_value[i];
        end
    end

    assign bus.slot_active   = w_active;
    assign bus.trigger_ready = w_ready;
    assign bus.dropped_count = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_score_popup_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_popup_engine
// Brief    : Randomized scoreboard bench; second DUT uses FADE_STEP=8'h40.
// Revision : 1.0
// ============================================================================
module tb_score_popup_engine;

    localparam int NS = 4;
    localparam int ST = 8;
    localparam int FP = 16;
    localparam int LIFE = ST * FP;

    logic frame_clk = 1'b0;
    logic reset     = 1'b0;

    always #5 frame_clk = ~frame_clk;

    score_popup_if #(.NUM_SLOTS(NS)) bus_a ();
    score_popup_if #(.NUM_SLOTS(NS)) bus_b ();

    assign bus_b.clear         = bus_a.clear;
    assign bus_b.trigger       = bus_a.trigger;
    assign bus_b.trigger_value = bus_a.trigger_value;

    score_popup_engine #(
        .NUM_SLOTS(NS), .STEPS(ST), .FRAMES_PER_STEP(FP),
        .FADE_STEP(8'h20), .RISE_STEP(10'd1)
    ) u_dut_a (
        .frame_clk (frame_clk),
        .reset     (reset),
        .bus       (bus_a.slave)
    );

    score_popup_engine #(
        .NUM_SLOTS(NS), .STEPS(ST), .FRAMES_PER_STEP(FP),
        .FADE_STEP(8'h40), .RISE_STEP(10'd1)
    ) u_dut_b (
        .frame_clk (frame_clk),
        .reset     (reset),
        .bus       (bus_b.slave)
    );

    typedef struct packed {
        logic          ready;
        logic [NS-1:0] active;
        logic [NS*10-1:0] y;
        logic [NS*8-1:0]  fade;
        logic [NS*8-1:0]  fade_b;
        logic [NS*8-1:0]  value;
        logic [7:0]       dropped;
    } exp_t;

    exp_t q_exp [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each popup is just an age counter since launch.
    bit  m_busy [NS];
    int  m_age  [NS];
    int  m_val  [NS];
    int  m_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fade_of(input int step, input int inc);
        int f;
        f = step * inc;
        return (f > 255) ? 255 : f;
    endfunction

    task automatic model_edge(input bit rst, input bit clr, input bit trg, input int val);
        exp_t e;
        int   pick;
        if (rst || clr) begin
            for (int i = 0; i < NS; i++) m_busy[i] = 0;
            if (rst) m_drop = 0;
        end else begin
            pick = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_busy[i]) pick = i;
            if (trg && pick < 0 && m_drop < 255) m_drop++;
            for (int i = 0; i < NS; i++) begin
                if (m_busy[i]) begin
                    m_age[i]++;
                    if (m_age[i] == LIFE) m_busy[i] = 0;
                end
            end
            if (trg && pick >= 0) begin
                m_busy[pick] = 1;
                m_age[pick]  = 0;
                m_val[pick]  = val;
            end
        end
        e = '0;
        e.ready   = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (m_busy[i]) begin
                e.active[i]        = 1'b1;
                e.y[10*i +: 10]    = 10'((m_age[i] / FP) * 1);
                e.fade[8*i +: 8]   = 8'(fade_of(m_age[i] / FP, 32));
                e.fade_b[8*i +: 8] = 8'(fade_of(m_age[i] / FP, 64));
                e.value[8*i +: 8]  = 8'(m_val[i]);
            end else begin
                e.ready = 1'b1;
            end
        end
        e.dropped = 8'(m_drop);
        q_exp.push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit clr, input bit trg, input int val);
        @(negedge frame_clk);
        reset               = rst;
        bus_a.clear         = clr;
        bus_a.trigger       = trg;
        bus_a.trigger_value = 8'(val);
        @(posedge frame_clk);
        model_edge(rst, clr, trg, val);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("trigger_ready", 64'(bus_a.trigger_ready), 64'(e.ready));
                check("slot_active",   64'(bus_a.slot_active),   64'(e.active));
                check("slot_y",        64'(bus_a.slot_y),        64'(e.y));
                check("slot_fade",     64'(bus_a.slot_fade),     64'(e.fade));
                check("slot_value",    64'(bus_a.slot_value),    64'(e.value));
                check("dropped_count", 64'(bus_a.dropped_count), 64'(e.dropped));
                check("slot_fade_sat", 64'(bus_b.slot_fade),     64'(e.fade_b));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r;
        for (int i = 0; i < NS; i++) begin
            m_busy[i] = 0; m_age[i] = 0; m_val[i] = 0;
        end
        m_drop              = 0;
        bus_a.clear         = 1'b0;
        bus_a.trigger       = 1'b0;
        bus_a.trigger_value = 8'h00;

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Single popup lifetime.
        cycle(0, 0, 1, 8'h0A);
        idle(LIFE + 4);

        // Fill all slots, overflow twice, then probe the reuse boundary.
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'h10 + k);
        cycle(0, 0, 1, 8'hE5);
        cycle(0, 0, 1, 8'hE6);
        idle(LIFE - 6);
        cycle(0, 0, 1, 8'h77);
        cycle(0, 0, 1, 8'h78);
        idle(20);

        // Clear mid-run with a simultaneous trigger.
        cycle(0, 0, 1, 8'h31);
        cycle(0, 0, 1, 8'h32);
        idle(48);
        cycle(0, 1, 1, 8'h33);
        idle(3);

        // Randomized traffic with occasional clear.
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 63));
            cycle(0, (r == 0), (r < 14), int'($urandom_range(0, 255)));
        end

        // Reset with trigger and clear asserted mid-animation.
        cycle(0, 0, 1, 8'h44);
        idle(40);
        cycle(1, 1, 1, 8'h55);
        idle(2);

        // Sustained overflow to saturate the drop counter.
        for (int k = 0; k < 300; k++) cycle(0, 0, 1, k & 255);
        idle(LIFE + 2);
        cycle(1, 0, 0, 0);
        idle(2);

        @(negedge frame_clk);
        @(negedge frame_clk);
        check("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_popup_engine.md
SCORE_POPUP_ENGINE -- requirements
Module: score_popup_engine

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of concurrent popups (1..16).
REQ-002 SHALL have parameter STEPS, default 8, animation steps per popup (2..64).
REQ-003 SHALL have parameter FRAMES_PER_STEP, default 16, frames per step (2..256).
REQ-004 SHALL have parameter FADE_STEP, default 8'h20, fade increment per step.
REQ-005 SHALL have parameter RISE_STEP, default 1, pixel offset increment per step (10-bit).
REQ-006 SHALL have port frame_clk  in  1  clock, one edge per video frame.
REQ-007 SHALL have port reset  in  1  synchronous, active-high.
REQ-008 SHALL have port clear  in  1  synchronous retire of all slots, for example on game over.
REQ-009 SHALL have port trigger  in  1  request to launch a popup.
REQ-010 SHALL have port trigger_value  in  8  score value carried by the popup.
REQ-011 SHALL have port trigger_ready  out  1  at least one slot idle.
REQ-012 SHALL have port slot_active  out  NUM_SLOTS  per-slot busy flag.
REQ-013 SHALL have port slot_y  out  NUM_SLOTS*10  per-slot vertical offset; slot i occupies bits [10i+9:10i].
REQ-014 SHALL have port slot_fade  out  NUM_SLOTS*8  per-slot fade amount; the renderer draws 8'hFF minus fade.
REQ-015 SHALL have port slot_value  out  NUM_SLOTS*8  per-slot latched trigger_value.
REQ-016 SHALL have port dropped_count  out  8  count of triggers rejected because no slot was free.

Function
REQ-017 SHALL give each slot two states, IDLE and RUN, with registers divider, step, y, fade, value.
REQ-018 SHALL drive trigger_ready combinationally as the OR of ~slot_active, using the current-cycle state only.
REQ-019 SHALL accept a trigger when trigger=1 and trigger_ready=1 and clear=0, allocating the lowest-index IDLE slot.
REQ-020 SHALL, on the accepting edge, set the allocated slot to RUN with divider=0, step=0, y=0, fade=0, value=trigger_value; the slot is visible active on the next cycle.
REQ-021 SHALL accept at most one trigger per frame_clk edge.
REQ-022 SHALL, in RUN, increment divider each edge; when divider==FRAMES_PER_STEP-1, divider wraps to 0.
REQ-023 SHALL, on a divider wrap with step<STEPS-1, perform step+1, y+RISE_STEP, and fade+FADE_STEP saturating at 8'hFF.
REQ-024 SHALL, on a divider wrap with step==STEPS-1, return the slot to IDLE with y, fade, value, divider, step all 0.
REQ-025 SHALL keep every slot in RUN for exactly STEPS*FRAMES_PER_STEP edges.
REQ-026 SHALL force slot_y and slot_fade to 0 while a slot is IDLE.
REQ-027 SHALL NOT make a slot retiring on an edge reusable by a trigger on that same edge; it becomes reusable on the next edge.
REQ-028 SHALL, on trigger=1 with no free slot and clear=0, increment dropped_count, saturating at 8'hFF.
REQ-029 SHALL, on clear=1, put all slots in IDLE with zeroed registers on that edge, ignore trigger, and leave dropped_count unchanged.
REQ-030 SHALL advance all slots independently and in parallel; slots launched on different edges keep their own phase.

Reset
REQ-031 SHALL, on reset=1 at a frame_clk edge, set all slots IDLE and dropped_count=0, giving slot_active=0, slot_y=0, slot_fade=0, slot_value=0, trigger_ready=1.
REQ-032 SHALL give reset priority over clear and trigger.
REQ-033 SHALL let reset abort running popups mid-animation without leaving residual outputs.

Verification (default parameters)
REQ-034 Single popup: trigger with value 8'h0A -> slot 0 active for 128 edges; y steps 0..7 and fade steps 0..224 at every 16th edge; then idle and all outputs 0.
REQ-035 Allocation: 4 triggers on consecutive edges -> slots 0,1,2,3 active, each retiring 1 edge after the previous; trigger_ready=0 while all four run.
REQ-036 Overflow: a 5th and 6th trigger while 4 slots are busy -> dropped_count=2, no slot state changed; 300 overflowing triggers -> dropped_count=8'hFF.
REQ-037 Reuse boundary: a trigger on the exact edge slot 0 retires, with others busy -> dropped; the same trigger one edge later -> slot 0 allocated.
REQ-038 Clear/reset mid-run: clear at edge 50 with trigger=1 -> all slots idle next cycle, dropped_count unchanged; reset mid-run -> REQ-031 values.
REQ-039 Saturation: FADE_STEP=8'h40 and STEPS=8 -> fade sequence 0,64,128,192,255,255,255,255.
